// File: rtl/priority_encoder_rr.sv
// Registered N-way grant encoder: fixed highest-index priority or round-robin,
// with a valid/ready output that holds the grant while the consumer stalls.
module priority_encoder_rr #(
  parameter int N       = 8,
  parameter int RR_MODE = 0,
  localparam int W      = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         o_dbg_state
);

  // Handshake: a grant is transferred on every rising edge where out_valid
  // and out_ready are both 1; while out_valid=1 and out_ready=0 the grant is
  // frozen, and an empty grant register (IDLE) reloads on every edge.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr;

  logic [N-1:0] w_eff;
  logic         w_any;
  logic         w_load;
  logic [W-1:0] w_win;
  logic [W-1:0] w_ptr_nxt;
  logic         w_found;
  int           w_pos;

  assign w_eff  = req & ~mask;
  assign w_any  = |w_eff;
  assign w_load = (r_state == IDLE) || out_ready;

  // Winner selection; round-robin walks downward from r_ptr and wraps to N-1.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < N; i++) begin
        if (i <= int'(r_ptr)) w_pos = int'(r_ptr) - i;
        else                  w_pos = int'(r_ptr) + N - i;
        if (!w_found && w_eff[w_pos]) begin
          w_win   = W'(w_pos);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_eff[i]) w_win = W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_win == '0) ? W'(N - 1) : (w_win - W'(1));

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) w_state_nxt = w_any ? GRANT : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= W'(N - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_idx    <= w_win;
        r_onehot <= {{(N-1){1'b0}}, 1'b1} << w_win;
        if (RR_MODE != 0) r_ptr <= w_ptr_nxt;
      end else begin
        r_idx    <= '0;
        r_onehot <= '0;
      end
    end
  end

  assign out_valid   = (r_state == GRANT);
  assign out_idx     = r_idx;
  assign out_onehot  = r_onehot;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: fixed N=8, round-robin N=8 and round-robin N=5
// instances share stimulus and are compared every cycle to a behavioural model.
module tb_priority_encoder_rr;

  localparam int W = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       out_ready;

  logic       f_valid, r_valid, p_valid;
  logic [2:0] f_idx, r_idx, p_idx;
  logic [7:0] f_onehot, r_onehot;
  logic [4:0] p_onehot;
  logic       f_dbg, r_dbg, p_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // model state per instance: 0 = fixed N=8, 1 = rr N=8, 2 = rr N=5
  int m_valid[3];
  int m_idx[3];
  int m_ptr[3];
  int n_of[3]  = '{8, 8, 5};
  int rr_of[3] = '{0, 1, 1};

  priority_encoder_rr #(.N(8), .RR_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_ready(out_ready),
    .out_valid(f_valid), .out_idx(f_idx), .out_onehot(f_onehot), .o_dbg_state(f_dbg)
  );

  priority_encoder_rr #(.N(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_ready(out_ready),
    .out_valid(r_valid), .out_idx(r_idx), .out_onehot(r_onehot), .o_dbg_state(r_dbg)
  );

  priority_encoder_rr #(.N(5), .RR_MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(req[4:0]), .mask(mask[4:0]), .out_ready(out_ready),
    .out_valid(p_valid), .out_idx(p_idx), .out_onehot(p_onehot), .o_dbg_state(p_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: pick the winner straight from the priority rules
  function automatic int pick(input logic [63:0] eff, input int n, input int rr, input int ptr);
    int res;
    int c;
    res = -1;
    if (rr == 0) begin
      for (int k = 0; k < n; k++) if (eff[k]) res = k;
    end else begin
      for (int k = n - 1; k >= 0; k--) begin
        c = (ptr - k + n) % n;
        if (eff[c]) res = c;
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_valid[u] = 0;
      m_idx[u]   = 0;
      m_ptr[u]   = n_of[u] - 1;
    end
  endtask

  task automatic model_edge();
    logic [63:0] eff;
    int k;
    for (int u = 0; u < 3; u++) begin
      eff = {56'd0, req & ~mask} & ((64'd1 << n_of[u]) - 64'd1);
      if (m_valid[u] == 0 || out_ready) begin
        k = pick(eff, n_of[u], rr_of[u], m_ptr[u]);
        if (k < 0) begin
          m_valid[u] = 0;
          m_idx[u]   = 0;
        end else begin
          m_valid[u] = 1;
          m_idx[u]   = k;
          if (rr_of[u] != 0) m_ptr[u] = (k == 0) ? n_of[u] - 1 : k - 1;
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_oh(input int u);
    return (m_valid[u] != 0) ? (64'd1 << m_idx[u]) : 64'd0;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, " fix valid"}, 64'(f_valid), 64'(m_valid[0]));
    check_eq({tag, " fix idx"}, 64'(f_idx), 64'(m_idx[0]));
    check_eq({tag, " fix onehot"}, 64'(f_onehot), exp_oh(0));
    check_eq({tag, " fix state"}, 64'(f_dbg), 64'(m_valid[0]));
    check_eq({tag, " rr valid"}, 64'(r_valid), 64'(m_valid[1]));
    check_eq({tag, " rr idx"}, 64'(r_idx), 64'(m_idx[1]));
    check_eq({tag, " rr onehot"}, 64'(r_onehot), exp_oh(1));
    check_eq({tag, " rr5 valid"}, 64'(p_valid), 64'(m_valid[2]));
    check_eq({tag, " rr5 idx"}, 64'(p_idx), 64'(m_idx[2]));
    check_eq({tag, " rr5 onehot"}, 64'(p_onehot), exp_oh(2));
  endtask

  // driver tasks
  task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic rdy);
    req       = r;
    mask      = m;
    out_ready = rdy;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " fix valid"}, 64'(f_valid), 64'd0);
    check_eq({tag, " fix idx"}, 64'(f_idx), 64'd0);
    check_eq({tag, " fix onehot"}, 64'(f_onehot), 64'd0);
    check_eq({tag, " rr valid"}, 64'(r_valid), 64'd0);
    check_eq({tag, " rr idx"}, 64'(r_idx), 64'd0);
    check_eq({tag, " rr onehot"}, 64'(r_onehot), 64'd0);
    check_eq({tag, " rr5 valid"}, 64'(p_valid), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 1'b1);
    model_reset();
    #3 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // fixed-priority selection
    drive(8'h16, 8'h00, 1'b1);
    step("s1");
    check_eq("s1 fix idx=4", 64'(f_idx), 64'd4);
    check_eq("s1 fix onehot=10", 64'(f_onehot), 64'h10);

    // back-pressure: grant frozen while stalled
    drive(8'h80, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("s2 stall");
      check_eq("s2 fix idx held", 64'(f_idx), 64'd4);
    end
    out_ready = 1'b1;
    step("s2 release");
    check_eq("s2 fix idx=7", 64'(f_idx), 64'd7);

    // masking
    drive(8'hFF, 8'hC0, 1'b1);
    step("s3 mask");
    check_eq("s3 fix idx=5", 64'(f_idx), 64'd5);
    mask = 8'hFF;
    step("s3 all masked");
    check_eq("s3 fix valid=0", 64'(f_valid), 64'd0);
    check_eq("s3 fix onehot=0", 64'(f_onehot), 64'd0);

    // round-robin rotation
    do_reset("s4 rst");
    drive(8'hFF, 8'h00, 1'b1);
    for (int i = 7; i >= 0; i--) exp_q.push_back(W'(i));
    exp_q.push_back(W'(7));
    while (exp_q.size() > 0) begin
      step("s4");
      check_eq("s4 rr idx", 64'(r_idx), 64'(exp_q.pop_front()));
      check_eq("s4 rr valid", 64'(r_valid), 64'd1);
    end

    // round-robin fairness between two channels
    do_reset("s5 rst");
    drive(8'h81, 8'h00, 1'b1);
    exp_q = '{W'(7), W'(0), W'(7), W'(0)};
    while (exp_q.size() > 0) begin
      step("s5");
      check_eq("s5 rr idx", 64'(r_idx), 64'(exp_q.pop_front()));
    end

    // reset mid-grant discards the grant asynchronously
    do_reset("s6 pre");
    drive(8'hFF, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step("s6 run");
    do_reset("s6 async");
    step("s6 after");
    check_eq("s6 rr first=7", 64'(r_idx), 64'd7);
    check_eq("s6 fix first=7", 64'(f_idx), 64'd7);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset("rand rst");
      if ($urandom_range(0, 2) == 0) req = 8'($urandom() & $urandom() & $urandom());
      else                           req = 8'($urandom());
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/priority_encoder_rr.md
PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter N, default 8: number of request inputs; legal range 2..64.
REQ-003 Parameter RR_MODE, default 0: 0 = fixed priority with the highest index winning; 1 = round-robin.
REQ-004 Localparam W SHALL be clog2(N), giving 3 at the default N.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  N  request vector; bit i is channel i.
REQ-008 mask  input  N  per-channel disable; 1 = ignore req[i].
REQ-009 out_ready  input  1  consumer accepts the current grant.
REQ-010 out_valid  output  1  grant register holds a valid grant.
REQ-011 out_idx  output  W  binary index of the granted channel.
REQ-012 out_onehot  output  N  one-hot grant, equal to 1 << out_idx when valid, else 0.

Function
REQ-013 The effective request SHALL be eff = req & ~mask, evaluated combinationally each cycle.
REQ-014 All outputs SHALL be registered, with no combinational path from req, mask or out_ready to any output.
REQ-015 The FSM SHALL have two states: IDLE (out_valid=0) and GRANT (out_valid=1).
REQ-016 A load event SHALL occur at a rising edge when state=IDLE, or when state=GRANT and out_ready=1.
REQ-017 At a load event with eff != 0, the block SHALL register the winner, set out_valid=1 and enter GRANT.
REQ-018 At a load event with eff == 0, the block SHALL set out_valid=0, out_idx=0 and out_onehot=0, and enter IDLE.
REQ-019 In GRANT with out_ready=0, out_idx and out_onehot SHALL hold unchanged regardless of req or mask changes, including deassertion or masking of the granted channel.
REQ-020 Latency SHALL be one cycle from eff being presented to the grant appearing at the outputs.
REQ-021 Throughput SHALL be one grant per cycle while out_ready=1 and eff != 0.
REQ-022 Fixed mode: the winner SHALL be the highest set index of eff.
REQ-023 Round-robin mode: a pointer ptr (W bits) SHALL mark the highest-priority channel.
REQ-024 Round-robin mode: the search SHALL run downward from ptr, wrapping from 0 to N-1, and the first set eff bit SHALL win.
REQ-025 Round-robin mode: on each load with a winner k, ptr SHALL update to k-1, or to N-1 when k=0.
REQ-026 Round-robin mode: ptr SHALL be unchanged on loads with eff == 0 and on non-load cycles.
REQ-027 Fixed mode SHALL not use ptr; ptr SHALL stay at N-1.
REQ-028 When N is not a power of two, out_idx SHALL never exceed N-1.
REQ-029 Simultaneous acceptance and a new request SHALL be handled in the same edge, giving back-to-back grants without a bubble.

Reset
REQ-030 While rst_n=0, asynchronously: out_valid=0, out_idx=0, out_onehot=0, state=IDLE, ptr=N-1.
REQ-031 Reset asserted mid-GRANT SHALL discard the pending grant immediately, without waiting for a clock edge.
REQ-032 The first load SHALL occur at the first rising edge after rst_n deasserts.

Verification (N=8)
REQ-033 Scenario 1 SHALL cover fixed-priority selection: RR_MODE=0, req=8'h16, mask=0, out_ready=1 -> next edge out_valid=1, out_idx=4, out_onehot=8'h10.
REQ-034 Scenario 2 SHALL cover back-pressure: out_ready=0 while out_idx=4, then req changed to 8'h80 -> out_idx stays 4 for every stalled cycle; raise out_ready -> next edge out_idx=7.
REQ-035 Scenario 3 SHALL cover masking: RR_MODE=0, req=8'hFF, mask=8'hC0 -> out_idx=5; then mask=8'hFF -> out_valid=0, out_onehot=0 after the next load.
REQ-036 Scenario 4 SHALL cover round-robin rotation: RR_MODE=1, req=8'hFF held, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, with out_valid=1 throughout.
REQ-037 Scenario 5 SHALL cover round-robin fairness: RR_MODE=1, req=8'h81 held, out_ready=1 -> out_idx alternates 7,0,7,0.
REQ-038 Scenario 6 SHALL cover reset mid-grant: rst_n pulsed low mid-sequence in scenario 4 -> out_valid=0 and out_idx=0 immediately; after release, the first grant is 7.
REQ-039 Across all scenarios, out_onehot SHALL equal 1 << out_idx whenever out_valid=1, and SHALL be 0 otherwise.
